// File: rtl/crosshair_pkg.sv
// crosshair_pkg
//   Shared definitions for the crosshair renderer.
//   - state_t : FSM encoding of the drawer (IDLE, CENTER, ARM, DONE)
//   - dir_t   : arm direction, visited in the order top, right, bottom, left
package crosshair_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CENTER = 2'd1,
      ARM    = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_TOP    = 2'd0;
   localparam dir_t DIR_RIGHT  = 2'd1;
   localparam dir_t DIR_BOTTOM = 2'd2;
   localparam dir_t DIR_LEFT   = 2'd3;

endpackage

// File: rtl/crosshair_clip.sv
// crosshair_clip
//   Combinational pixel generator for one crosshair slot. Offsets the centre
//   by k pixels in direction dir and reports whether the result lies on the
//   visible screen.
//   Ports:
//     cx, cy     : centre point
//     dir        : arm direction (top/right/bottom/left)
//     k          : offset from the centre; k = 0 yields the centre pixel
//     x, y       : resulting pixel (only meaningful when on_screen = 1)
//     on_screen  : 1 when 0 <= x < SCREEN_W and 0 <= y < SCREEN_H
module crosshair_clip
   import crosshair_pkg::*;
#(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int ARM_W    = 4
) (
   input  logic [X_W-1:0]   cx,
   input  logic [Y_W-1:0]   cy,
   input  dir_t             dir,
   input  logic [ARM_W-1:0] k,
   output logic [X_W-1:0]   x,
   output logic [Y_W-1:0]   y,
   output logic             on_screen
);

   localparam logic [X_W:0] SW = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] SH = (Y_W+1)'(SCREEN_H);

   // One extra bit turns the coordinate into a two's complement value: a
   // step left/up past 0 sets the top bit, and a step right/down past the
   // X_W-bit range also lands with the top bit set. Both cases are beyond
   // the screen, so a set top bit always means clipped.
   logic [X_W:0] cx_e, kx, xs;
   logic [Y_W:0] cy_e, ky, ys;

   assign cx_e = {1'b0, cx};
   assign cy_e = {1'b0, cy};
   assign kx   = (X_W+1)'(k);
   assign ky   = (Y_W+1)'(k);

   always_comb begin
      xs = cx_e;
      ys = cy_e;
      case (dir)
         DIR_TOP:    ys = cy_e - ky;
         DIR_RIGHT:  xs = cx_e + kx;
         DIR_BOTTOM: ys = cy_e + ky;
         default:    xs = cx_e - kx;
      endcase
   end

   assign on_screen = !xs[X_W] && (xs < SW) && !ys[Y_W] && (ys < SH);
   assign x         = xs[X_W-1:0];
   assign y         = ys[Y_W-1:0];

endmodule

// File: rtl/crosshair_drawer.sv
// crosshair_drawer
//   Run-time configurable crosshair renderer. On start it latches a centre,
//   arm length, centre gap and colour, then streams the pixels (centre, then
//   top, right, bottom and left arms) to the VGA adapter write port one per
//   accepted handshake. Off-screen pixels are clipped and skipped pixels
//   take one silent cycle.
//   Ports:
//     clock, reset      : rising-edge clock, synchronous active-low reset
//     start             : draw request, sampled only while idle
//     center_x/center_y : centre point
//     arm_len, gap      : arm pixels at offsets gap+1 .. arm_len are drawn
//     colour            : pixel colour
//     show_center       : draw the centre pixel
//     vga_ready         : adapter accepts the presented write
//     busy, done        : draw in progress / one-cycle completion pulse
//     vga_x, vga_y      : registered pixel position
//     vga_colour        : latched colour
//     vga_write         : registered pixel valid
module crosshair_drawer
   import crosshair_pkg::*;
#(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int ARM_W    = 4,
   parameter int COLOUR_W = 18
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [X_W-1:0]      center_x,
   input  logic [Y_W-1:0]      center_y,
   input  logic [ARM_W-1:0]    arm_len,
   input  logic [ARM_W-1:0]    gap,
   input  logic [COLOUR_W-1:0] colour,
   input  logic                show_center,
   input  logic                vga_ready,
   output logic                busy,
   output logic                done,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_write
);

   // The registered state (state, dir_q, k_q) always names the pixel that is
   // currently presented on the vga_* outputs. Each cycle the next slot is
   // worked out combinationally, clipped, and registered together with its
   // coordinates, so vga_ready only ever reaches the outputs through a flop.
   state_t           state, nxt_state;
   dir_t             dir_q, nxt_dir;
   logic [ARM_W-1:0] k_q, nxt_k;
   logic [ARM_W-1:0] len_q, gap_q;
   logic [X_W-1:0]   cx_q, src_cx;
   logic [Y_W-1:0]   cy_q, src_cy;
   logic             nxt_show;
   logic             nxt_write;
   logic             adv;
   logic             accept;

   logic [X_W-1:0]   clip_x;
   logic [Y_W-1:0]   clip_y;
   logic             clip_on;

   // A silent slot always moves on; a presented pixel waits for the adapter.
   assign adv    = !vga_write || vga_ready;
   assign accept = (state == IDLE) && start;

   // While idle the centre comes straight from the inputs so the first pixel
   // can be presented in the cycle right after start is accepted.
   assign src_cx = (state == IDLE) ? center_x : cx_q;
   assign src_cy = (state == IDLE) ? center_y : cy_q;

   always_comb begin
      nxt_state = state;
      nxt_dir   = dir_q;
      nxt_k     = k_q;
      // Staying in CENTER only happens while a visible centre pixel stalls,
      // which implies show_center was set when it was launched.
      nxt_show  = 1'b1;
      case (state)
         IDLE: begin
            if (start) begin
               nxt_state = CENTER;
               nxt_dir   = DIR_TOP;
               nxt_k     = '0;
               nxt_show  = show_center;
            end
         end
         CENTER: begin
            if (adv) begin
               if (gap_q >= len_q) begin
                  nxt_state = DONE;
               end else begin
                  nxt_state = ARM;
                  nxt_dir   = DIR_TOP;
                  nxt_k     = gap_q + ARM_W'(1);
               end
            end
         end
         ARM: begin
            if (adv) begin
               if (k_q == len_q) begin
                  if (dir_q == DIR_LEFT) begin
                     nxt_state = DONE;
                  end else begin
                     nxt_dir = dir_q + 2'd1;
                     nxt_k   = gap_q + ARM_W'(1);
                  end
               end else begin
                  nxt_k = k_q + ARM_W'(1);
               end
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   crosshair_clip #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .ARM_W    (ARM_W)
   ) u_clip (
      .cx        (src_cx),
      .cy        (src_cy),
      .dir       (nxt_dir),
      .k         (nxt_k),
      .x         (clip_x),
      .y         (clip_y),
      .on_screen (clip_on)
   );

   assign nxt_write = clip_on &&
                      (((nxt_state == CENTER) && nxt_show) || (nxt_state == ARM));

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         dir_q      <= DIR_TOP;
         k_q        <= '0;
         len_q      <= '0;
         gap_q      <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_write  <= 1'b0;
      end else begin
         state     <= nxt_state;
         dir_q     <= nxt_dir;
         k_q       <= nxt_k;
         vga_write <= nxt_write;
         // Clipped coordinates never reach the port; x/y just hold.
         if (nxt_write) begin
            vga_x <= clip_x;
            vga_y <= clip_y;
         end
         if (accept) begin
            cx_q       <= center_x;
            cy_q       <= center_y;
            len_q      <= arm_len;
            gap_q      <= gap;
            vga_colour <= colour;
            busy       <= 1'b1;
         end else if (state == DONE) begin
            busy <= 1'b0;
         end
         // DONE always returns to IDLE, so this is a single-cycle pulse.
         done <= (nxt_state == DONE);
      end
   end

endmodule

// File: doc/crosshair_drawer.md
# crosshair_drawer

- Parametrised, run-time-configurable crosshair renderer; successor to the fixed 5-pixel crosshair drawer.
- On `start`, latches a centre point, arm length, centre gap and colour.
- Streams the pixels one at a time to the VGA adapter write port:
  - centre pixel first, then the top, right, bottom and left arms;
  - honours a ready handshake;
  - clips pixels that fall off-screen.
- Sits between the frame-render sequencer and the VGA adapter, after the wall/sprite passes.

## Interface
Parameters:
- `X_W`, 8, vga_x width
- `Y_W`, 7, vga_y width
- `SCREEN_W`, 160, visible columns; x ≥ SCREEN_W is off-screen
- `SCREEN_H`, 120, visible rows
- `ARM_W`, 4, width of arm_len/gap (max arm 15)
- `COLOUR_W`, 18, colour width

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low; one clock, reset is synchronous and active-low
- `start`  in  1  request a draw; sampled only in IDLE
- `center_x`  in  X_W  centre column, in pixels
- `center_y`  in  Y_W  centre row, in pixels
- `arm_len`  in  ARM_W  outermost arm offset
- `gap`  in  ARM_W  arm pixels with offset ≤ gap are not drawn
- `colour`  in  COLOUR_W  pixel colour
- `show_center`  in  1  draw the centre pixel
- `vga_ready`  in  1  adapter accepts the current write
- `busy`  out  1  high from the cycle after start until DONE exits
- `done`  out  1  one-cycle pulse at completion
- `vga_x`  out  X_W  registered pixel column
- `vga_y`  out  Y_W  registered pixel row
- `vga_colour`  out  COLOUR_W  latched colour
- `vga_write`  out  1  pixel valid

## Operation
- **Reset** (reset=0 at an edge):
  - state → IDLE; counters cleared.
  - busy, done, vga_write = 0; vga_x, vga_y, vga_colour = 0.
  - Applies mid-draw: the pending pixel is abandoned, no done pulse.
- **IDLE, start=1:** latch all inputs; next state CENTER. In any other state start is ignored and inputs are not re-sampled.
- **CENTER:** pixel (cx, cy); skipped if show_center=0.
- **ARM:**
  - Direction `dir` counts 0..3: top (cx, cy−k), right (cx+k, cy), bottom (cx, cy+k), left (cx−k, cy).
  - Offset k runs gap+1 .. arm_len.
  - Empty arm range (gap ≥ arm_len): ARM is skipped and the next state is DONE.
  - After k=arm_len: dir increments and k reloads to gap+1. After dir=3: DONE.
- **DONE:** done=1 for one cycle → IDLE.
- **Arithmetic:** coordinates computed at X_W+1 / Y_W+1 bits as two's complement. A pixel is on-screen iff 0 ≤ x < SCREEN_W and 0 ≤ y < SCREEN_H. No wrap-around ever reaches vga_x/vga_y.
- **Handshake:**
  - An on-screen pixel presents vga_write=1 with stable x/y/colour.
  - The pixel advances only on a cycle with vga_write & vga_ready.
  - A clipped or skipped pixel occupies exactly one cycle with vga_write=0.

## Timing
- Start accepted at edge T → first pixel presented in cycle T+1.
- With vga_ready tied high: total busy cycles = 1 (centre slot) + 4·max(0, arm_len−gap) + 1 (DONE).
- Each vga_ready=0 cycle on a valid pixel adds exactly one cycle.
- done and busy both high in the DONE cycle. busy=0 and IDLE on the next cycle; a new start is accepted there.
- vga_x, vga_y and vga_write are registered; no combinational path from vga_ready to the outputs.

## Structure
- Package `crosshair_pkg` holds:
  - state encoding: IDLE, CENTER, ARM, DONE;
  - direction constants: DIR_TOP=0, DIR_RIGHT=1, DIR_BOTTOM=2, DIR_LEFT=3.
- Sub-module `crosshair_clip`: combinational (cx, cy, dir, k) → (x, y, on_screen), parametrised by the screen size.
- FSM and counters live in the top module.

## Test plan
- **Defaults:** centre (80,60), arm_len=2, gap=0, show_center=1, ready=1 → 9 writes in order (80,60), (80,59), (80,58), (81,60), (82,60), (80,61), (80,62), (79,60), (78,60); done at start+10; busy for 10 cycles.
- **Gap:** arm_len=3, gap=1, show_center=0 → centre slot silent; 8 writes at offsets 2,3 per arm; done after 1+8+1 cycles.
- **Clipping:** centre (0,0), arm_len=2, gap=0 → writes only (0,0), (1,0), (2,0), (0,1), (0,2); left and top slots silent; total 10 cycles.
- **Backpressure:** vga_ready low 3 cycles on the first right-arm pixel → x/y held stable, write held high; done delayed by exactly 3 cycles.
- **Empty arms:** gap=5, arm_len=2 → only the centre is written; done at start+2.
- **Reset and start-while-busy:** reset=0 mid-arm → next cycle all outputs 0, no done. Then start held high throughout a draw → exactly one done per accepted start; inputs changed mid-draw have no effect.
